// File: rtl/shift_sequencer.sv
// Multi-cycle shared 32-bit shifter: one log-stage (16/8/4/2/1) per clock,
// round-robin arbitration between two requesters, valid/ready result port.
module shift_sequencer #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_amt,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_amt,
  input  logic        req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_id,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        rr_prio;     // 0: req0 wins a tie, 1: req1 wins a tie
  logic        grant_id;
  logic        accept;

  logic [31:0] sel_data;
  logic [4:0]  sel_amt;
  logic        sel_op;

  logic [31:0] acc;
  logic [4:0]  mask;
  logic [4:0]  amt_q;
  logic        op_q;
  logic        id_q;

  logic [2:0]  stage_k;
  logic [4:0]  stage_bit;
  logic [5:0]  stage_dist;
  logic [4:0]  mask_next;
  logic [31:0] acc_next;

  assign busy = (state != IDLE);

  // Grant is only offered in IDLE; ready follows valid combinationally.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    grant_id   = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid && req1_valid) grant_id = rr_prio;
        else                          grant_id = req1_valid;
        accept     = req0_valid || req1_valid;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        if (accept) begin
          if (SKIP_ZERO && (sel_amt == 5'd0)) state_next = DONE;
          else                                state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (mask_next == 5'd0) state_next = DONE;
      end
      DONE: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_data = grant_id ? req1_data : req0_data;
    sel_amt  = grant_id ? req1_amt  : req0_amt;
    sel_op   = grant_id ? req1_op   : req0_op;
  end

  // One stage per edge: highest remaining mask bit picks the distance 2^k.
  always_comb begin
    stage_k = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (mask[i]) stage_k = 3'(i);
    end
    stage_bit  = 5'd1 << stage_k;
    stage_dist = 6'd1 << stage_k;
    mask_next  = mask & ~stage_bit;
    if (!amt_q[stage_k]) acc_next = acc;
    else if (op_q)       acc_next = $unsigned($signed(acc) >>> stage_dist);
    else                 acc_next = acc << stage_dist;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_prio    <= 1'b0;
      acc        <= '0;
      mask       <= '0;
      amt_q      <= '0;
      op_q       <= 1'b0;
      id_q       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rr_prio <= ~grant_id;
            acc     <= sel_data;
            amt_q   <= sel_amt;
            op_q    <= sel_op;
            id_q    <= grant_id;
            mask    <= SKIP_ZERO ? sel_amt : 5'b11111;
            if (SKIP_ZERO && (sel_amt == 5'd0)) begin
              resp_valid <= 1'b1;
              resp_data  <= sel_data;
              resp_id    <= grant_id;
            end
          end
        end
        SHIFT: begin
          acc  <= acc_next;
          mask <= mask_next;
          if (mask_next == 5'd0) begin
            resp_valid <= 1'b1;
            resp_data  <= acc_next;
            resp_id    <= id_q;
          end
        end
        DONE: begin
          // Data and id intentionally persist after retire.
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
